// File: rtl/host_line_ctrl.sv
// Host-side line transfer controller: streams one NUM_BYTES line between a byte-wide
// host handshake and a line buffer addressed by bit offset.
module host_line_ctrl #(
    parameter int unsigned NUM_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_write,
    input  logic       start_read,
    input  logic       abort,
    input  logic [7:0] host_byte_in,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] host_byte_out,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] buf_rd_byte,
    output logic [7:0] buf_wr_byte,
    output logic [8:0] buf_offset,
    output logic       buf_wr,
    output logic       busy,
    output logic       line_done
);

    localparam int unsigned CntW = $clog2(NUM_BYTES);
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      cnt_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        host_ready = 1'b0;
        out_valid  = 1'b0;
        buf_wr     = 1'b0;
        line_done  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_write) begin
                    state_d = StWrite;
                end else if (start_read) begin
                    state_d = StRead;
                end
            end
            StWrite: begin
                host_ready = 1'b1;
                // The byte offered in an abort cycle is still written.
                buf_wr     = host_valid;
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (host_valid) begin
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRead: begin
                out_valid = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                line_done = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        // Reset is synchronous, so outputs are masked while it is asserted.
        if (rst) begin
            host_ready = 1'b0;
            out_valid  = 1'b0;
            buf_wr     = 1'b0;
            line_done  = 1'b0;
        end
    end

    assign cnt_ext       = rst ? 6'd0 : 6'(cnt_q);
    assign buf_offset    = {cnt_ext, 3'b111};
    assign busy          = !rst && (state_q != StIdle);
    assign buf_wr_byte   = host_byte_in;
    assign host_byte_out = buf_rd_byte;

endmodule

// File: tb/tb_host_line_ctrl.sv
// Bench for host_line_ctrl: fixed vector table, directed line sequences and random
// stimulus, all checked against a transaction-level model of the line transfer.
module tb_host_line_ctrl;

    localparam int N = 64;
    localparam int MdIdle = 0, MdWrite = 1, MdRead = 2, MdDone = 3;

    logic       clk = 1'b0;
    logic       rst, start_write, start_read, abort, host_valid, out_ready;
    logic [7:0] host_byte_in;
    logic       host_ready, out_valid, buf_wr, busy, line_done;
    logic [7:0] host_byte_out, buf_rd_byte, buf_wr_byte;
    logic [8:0] buf_offset;

    always #5 clk = ~clk;

    host_line_ctrl #(.NUM_BYTES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_write  (start_write),
        .start_read   (start_read),
        .abort        (abort),
        .host_byte_in (host_byte_in),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_byte_out(host_byte_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .buf_rd_byte  (buf_rd_byte),
        .buf_wr_byte  (buf_wr_byte),
        .buf_offset   (buf_offset),
        .buf_wr       (buf_wr),
        .busy         (busy),
        .line_done    (line_done)
    );

    // Line buffer seen by the DUT.
    logic [8*N-1:0] tb_buf = '0;
    assign buf_rd_byte = tb_buf[buf_offset -: 8];
    always @(posedge clk) if (buf_wr) tb_buf[buf_offset -: 8] <= buf_wr_byte;

    int n_vec = 0;
    int n_err = 0;
    int wr_seen, done_seen, rd_seen;
    logic [7:0] rx_q[$];

    // Reference model: current transfer kind, bytes moved so far, expected line contents.
    int         m_mode = MdIdle;
    int         m_idx  = 0;
    logic [7:0] m_mem[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; start_write = 0; start_read = 0; abort = 0;
        host_valid = 0; host_byte_in = 8'h00; out_ready = 0;
    endtask

    task automatic step();
        logic [29:0] act, exp;
        logic [7:0]  exp_out;
        int          eidx;
        bit          live;
        #4;
        live    = !rst;
        eidx    = live ? m_idx : 0;
        exp_out = (live && m_mode == MdRead) ? m_mem[m_idx] : tb_buf[8*eidx+7 -: 8];
        exp = {live && m_mode == MdWrite, live && m_mode == MdRead,
               live && m_mode == MdWrite && host_valid, live && m_mode != MdIdle,
               live && m_mode == MdDone, 9'(8*eidx + 7), host_byte_in, exp_out};
        act = {host_ready, out_valid, buf_wr, busy, line_done, buf_offset, buf_wr_byte,
               host_byte_out};
        check("cycle", 64'(act), 64'(exp));
        if (buf_wr) wr_seen++;
        if (line_done) done_seen++;
        if (out_valid && out_ready) begin
            rd_seen++;
            rx_q.push_back(host_byte_out);
        end
        @(posedge clk);
        if (rst) begin
            m_mode = MdIdle;
            m_idx  = 0;
        end else if (m_mode == MdIdle) begin
            if (start_write) m_mode = MdWrite;
            else if (start_read) m_mode = MdRead;
        end else if (m_mode == MdDone) begin
            m_mode = MdIdle;
        end else begin
            if (m_mode == MdWrite && host_valid) m_mem[m_idx] = host_byte_in;
            if (abort) begin
                m_mode = MdIdle;
                m_idx  = 0;
            end else if ((m_mode == MdWrite) ? host_valid : out_ready) begin
                m_idx++;
                if (m_idx == N) begin
                    m_mode = MdDone;
                    m_idx  = 0;
                end
            end
        end
        #1;
    endtask

    typedef struct {
        logic       rst, sw, sr, ab, hv;
        logic [7:0] hb;
        logic       ordy;
        logic       hr, ov, bw, bsy, ld;
        logic [8:0] off;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int acc;
        //          rst sw sr ab hv  hb     ordy  hr ov bw bsy ld off
        tbl[0]  = '{1, 0, 0, 0, 0, 8'h00, 0,    0, 0, 0, 0, 0, 9'd7};
        tbl[1]  = '{0, 0, 0, 0, 0, 8'h00, 0,    0, 0, 0, 0, 0, 9'd7};
        tbl[2]  = '{0, 1, 1, 0, 0, 8'h00, 0,    0, 0, 0, 0, 0, 9'd7};
        tbl[3]  = '{0, 0, 1, 0, 1, 8'hA5, 0,    1, 0, 1, 1, 0, 9'd7};
        tbl[4]  = '{0, 0, 0, 0, 0, 8'h11, 0,    1, 0, 0, 1, 0, 9'd15};
        tbl[5]  = '{0, 0, 0, 0, 1, 8'h3C, 0,    1, 0, 1, 1, 0, 9'd15};
        tbl[6]  = '{0, 0, 0, 1, 1, 8'h77, 0,    1, 0, 1, 1, 0, 9'd23};
        tbl[7]  = '{0, 0, 0, 1, 0, 8'h00, 0,    0, 0, 0, 0, 0, 9'd7};
        tbl[8]  = '{0, 0, 1, 0, 0, 8'h00, 0,    0, 0, 0, 0, 0, 9'd7};
        tbl[9]  = '{0, 1, 0, 0, 0, 8'h00, 0,    0, 1, 0, 1, 0, 9'd7};
        tbl[10] = '{0, 0, 0, 0, 0, 8'h00, 1,    0, 1, 0, 1, 0, 9'd7};
        tbl[11] = '{0, 0, 0, 0, 0, 8'h00, 1,    0, 1, 0, 1, 0, 9'd15};
        tbl[12] = '{1, 0, 0, 0, 0, 8'h00, 1,    0, 0, 0, 0, 0, 9'd7};
        tbl[13] = '{0, 0, 0, 0, 0, 8'h00, 0,    0, 0, 0, 0, 0, 9'd7};

        for (int k = 0; k < N; k++) m_mem[k] = 8'h00;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; start_write = tbl[i].sw; start_read = tbl[i].sr;
            abort = tbl[i].ab; host_valid = tbl[i].hv; host_byte_in = tbl[i].hb;
            out_ready = tbl[i].ordy;
            #2;
            check("table", 64'({host_ready, out_valid, buf_wr, busy, line_done, buf_offset}),
                  64'({tbl[i].hr, tbl[i].ov, tbl[i].bw, tbl[i].bsy, tbl[i].ld, tbl[i].off}));
            step();
        end

        // Full line write 0x00..0x3F with no gaps.
        idle_inputs();
        start_write = 1;
        step();
        start_write = 0;
        wr_seen = 0; done_seen = 0;
        for (int k = 0; k < N; k++) begin
            host_valid = 1; host_byte_in = 8'(k);
            step();
        end
        check("write_strobes", 64'(wr_seen), 64'(N));
        host_valid = 0;
        step();
        step();
        check("write_done", 64'(done_seen), 64'd1);
        for (int k = 0; k < N; k++) check("write_data", 64'(tb_buf[8*k+7 -: 8]), 64'(k));

        // Read back with out_ready toggling.
        start_read = 1;
        step();
        start_read = 0;
        rd_seen = 0; done_seen = 0; rx_q.delete();
        for (int c = 0; rd_seen < N && c < 4 * N; c++) begin
            out_ready = (c % 2 == 0);
            step();
        end
        check("read_count", 64'(rd_seen), 64'(N));
        out_ready = 0;
        step();
        step();
        check("read_done", 64'(done_seen), 64'd1);
        for (int k = 0; k < N && k < rx_q.size(); k++) check("read_order", 64'(rx_q[k]), 64'(k));

        // Write with host_valid low every third cycle.
        start_write = 1;
        step();
        start_write = 0;
        wr_seen = 0; done_seen = 0; acc = 0;
        for (int c = 0; acc < N; c++) begin
            host_valid = (c % 3 != 2);
            host_byte_in = 8'(8'hC0 ^ acc);
            step();
            if (c % 3 != 2) acc++;
        end
        check("gap_strobes", 64'(wr_seen), 64'(N));
        host_valid = 0;
        step();
        step();
        check("gap_done", 64'(done_seen), 64'd1);

        // Abort after 10 bytes, then restart from offset 7.
        start_write = 1;
        step();
        start_write = 0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            host_valid = 1; host_byte_in = 8'(8'h50 + k);
            step();
        end
        host_valid = 0; abort = 1;
        step();
        abort = 0;
        step();
        check("abort_no_done", 64'(done_seen), 64'd0);
        start_write = 1;
        step();
        start_write = 0; host_valid = 1; host_byte_in = 8'hE7;
        #2;
        check("restart_offset", 64'(buf_offset), 64'd7);
        step();
        abort = 1; host_valid = 0;
        step();
        abort = 0;

        // Reset after 20 read transfers.
        start_read = 1;
        step();
        start_read = 0; out_ready = 1;
        for (int k = 0; k < 20; k++) step();
        rst = 1;
        step();
        rst = 0; out_ready = 0;
        #2;
        check("post_reset", 64'({host_ready, out_valid, buf_wr, busy, line_done, buf_offset}),
              64'({5'b0, 9'd7}));
        step();

        // Random stimulus.
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            start_write  = ($urandom_range(0, 3) == 0);
            start_read   = ($urandom_range(0, 3) == 0);
            abort        = ($urandom_range(0, 99) == 0);
            host_valid   = ($urandom_range(0, 3) != 0);
            host_byte_in = 8'($urandom);
            out_ready    = ($urandom_range(0, 1) == 1);
            step();
        end
        idle_inputs();
        step();
        for (int k = 0; k < N; k++) check("final_buf", 64'(tb_buf[8*k+7 -: 8]), 64'(m_mem[k]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
